// File: rtl/debounce_pkg.sv
// Shared types and default parameters for the dual-channel switch debouncer.
package debounce_pkg;

  localparam int unsigned DEFAULT_STABLE_CYCLES = 4;
  localparam int unsigned DEFAULT_CNT_WIDTH     = 8;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchronizer, stability counter, 4-state FSM,
// registered debounced level and single-cycle edge pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned CNT_WIDTH     = DEFAULT_CNT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  if ((STABLE_CYCLES < 2) ||
      (64'(STABLE_CYCLES) > ((64'(1) << CNT_WIDTH) - 64'(1)))) begin : g_bad_params
    $error("debounce_channel: STABLE_CYCLES must be in [2, 2**CNT_WIDTH-1]");
  end

  logic                 sync_a;
  logic                 sync_b;
  state_t               state;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] count_next;
  logic                 level_next;
  logic                 rise_next;
  logic                 fall_next;

  // Synchronizer: raw is asynchronous, only sync_b is used downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= STABLE_LO;
      count <= CNT_ZERO;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      level <= level_next;
      rise  <= rise_next;
      fall  <= fall_next;
    end
  end

  // Next state and counter; count saturates at CNT_LAST by leaving WAIT_*.
  always_comb begin
    state_next = state;
    count_next = count;
    unique case (state)
      STABLE_LO: begin
        if (sync_b) begin
          state_next = WAIT_HI;
          count_next = CNT_ONE;
        end else begin
          count_next = CNT_ZERO;
        end
      end
      WAIT_HI: begin
        if (!sync_b) begin
          state_next = STABLE_LO;
          count_next = CNT_ZERO;
        end else if (count == CNT_LAST) begin
          state_next = STABLE_HI;
          count_next = CNT_ZERO;
        end else begin
          count_next = count + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sync_b) begin
          state_next = WAIT_LO;
          count_next = CNT_ONE;
        end else begin
          count_next = CNT_ZERO;
        end
      end
      WAIT_LO: begin
        if (sync_b) begin
          state_next = STABLE_HI;
          count_next = CNT_ZERO;
        end else if (count == CNT_LAST) begin
          state_next = STABLE_LO;
          count_next = CNT_ZERO;
        end else begin
          count_next = count + CNT_ONE;
        end
      end
      default: begin
        state_next = STABLE_LO;
        count_next = CNT_ZERO;
      end
    endcase
  end

  // Output decode: level is high in STABLE_HI/WAIT_LO, pulses mark committed edges.
  always_comb begin
    level_next = 1'b0;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    level_next = (state_next == STABLE_HI) || (state_next == WAIT_LO);
    rise_next  = (state == WAIT_HI) && sync_b && (count == CNT_LAST);
    fall_next  = (state == WAIT_LO) && !sync_b && (count == CNT_LAST);
  end

endmodule

// File: rtl/dual_debounce.sv
// Two independent debounce channels feeding a downstream two-input gate.
module dual_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned CNT_WIDTH     = DEFAULT_CNT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic raw1,
  input  logic raw2,
  output logic in1,
  output logic in2,
  output logic rise1,
  output logic fall1,
  output logic rise2,
  output logic fall2
);

  debounce_channel #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_ch1 (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw1),
    .level (in1),
    .rise  (rise1),
    .fall  (fall1)
  );

  debounce_channel #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_ch2 (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw2),
    .level (in2),
    .rise  (rise2),
    .fall  (fall2)
  );

endmodule

// File: tb/tb_dual_debounce.sv
// Directed bench for dual_debounce with STABLE_CYCLES=4 and a NOR gate on in1/in2.
module tb_dual_debounce;

  logic clk;
  logic rst;
  logic raw1;
  logic raw2;
  logic in1;
  logic in2;
  logic rise1;
  logic fall1;
  logic rise2;
  logic fall2;
  logic gate;

  int n_cmp;
  int n_err;
  int rise1_cnt;
  int fall1_cnt;
  int rise2_cnt;
  int fall2_cnt;

  dual_debounce #(
    .STABLE_CYCLES (4),
    .CNT_WIDTH     (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .raw1  (raw1),
    .raw2  (raw2),
    .in1   (in1),
    .in2   (in2),
    .rise1 (rise1),
    .fall1 (fall1),
    .rise2 (rise2),
    .fall2 (fall2)
  );

  assign gate = ~(in1 | in2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    rise1_cnt += int'(rise1);
    fall1_cnt += int'(fall1);
    rise2_cnt += int'(rise2);
    fall2_cnt += int'(fall2);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [5:0] outs;
    rst  = 1'b1;
    raw1 = 1'b0;
    raw2 = 1'b0;
    #2;
    outs = {in1, in2, rise1, fall1, rise2, fall2};
    n_cmp++;
    if (outs !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected %b", outs, 6'b0);
    end
    tick(2);
    rst = 1'b0;
    tick(3);
    outs = {in1, in2, rise1, fall1, rise2, fall2};
    n_cmp++;
    if (outs !== 6'b0 || (rise1_cnt + fall1_cnt + rise2_cnt + fall2_cnt) != 0) begin
      n_err++;
      $display("FAIL reset_release: got outs=%b pulses=%0d expected outs=0 pulses=0",
               outs, rise1_cnt + fall1_cnt + rise2_cnt + fall2_cnt);
    end
  endtask

  task automatic test_rise_latency();
    raw1 = 1'b1;
    tick(5);
    n_cmp++;
    if (in1 !== 1'b0 || rise1 !== 1'b0) begin
      n_err++;
      $display("FAIL rise_edge5: got in1=%b rise1=%b expected 0 0", in1, rise1);
    end
    tick(1);
    n_cmp++;
    if ({in1, rise1, in2, rise2} !== 4'b1100) begin
      n_err++;
      $display("FAIL rise_edge6: got in1,rise1,in2,rise2=%b expected 1100", {in1, rise1, in2, rise2});
    end
    tick(1);
    n_cmp++;
    if (in1 !== 1'b1 || rise1 !== 1'b0) begin
      n_err++;
      $display("FAIL rise_pulse_width: got in1=%b rise1=%b expected 1 0", in1, rise1);
    end
    raw1 = 1'b0;
    tick(6);
    n_cmp++;
    if (in1 !== 1'b0 || fall1 !== 1'b1) begin
      n_err++;
      $display("FAIL fall_edge6: got in1=%b fall1=%b expected 0 1", in1, fall1);
    end
    tick(1);
    n_cmp++;
    if (fall1 !== 1'b0) begin
      n_err++;
      $display("FAIL fall_pulse_width: got fall1=%b expected 0", fall1);
    end
  endtask

  task automatic test_glitch();
    int r1;
    int f1;
    int bad;
    r1  = rise1_cnt;
    f1  = fall1_cnt;
    bad = 0;
    raw1 = 1'b1;
    tick(3);
    raw1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (in1 !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0 || rise1_cnt != r1 || fall1_cnt != f1) begin
      n_err++;
      $display("FAIL glitch_3cyc: got in1_high=%0d rise1=%0d fall1=%0d expected 0 0 0",
               bad, rise1_cnt - r1, fall1_cnt - f1);
    end
    // A pulse of exactly STABLE_CYCLES is long enough to pass.
    raw1 = 1'b1;
    tick(4);
    raw1 = 1'b0;
    tick(2);
    n_cmp++;
    if (in1 !== 1'b1 || rise1 !== 1'b1) begin
      n_err++;
      $display("FAIL pulse_4cyc_rise: got in1=%b rise1=%b expected 1 1", in1, rise1);
    end
    tick(4);
    n_cmp++;
    if (in1 !== 1'b0 || fall1 !== 1'b1) begin
      n_err++;
      $display("FAIL pulse_4cyc_fall: got in1=%b fall1=%b expected 0 1", in1, fall1);
    end
    tick(2);
  endtask

  task automatic test_simultaneous();
    raw1 = 1'b1;
    raw2 = 1'b1;
    tick(5);
    n_cmp++;
    if ({in1, in2} !== 2'b00) begin
      n_err++;
      $display("FAIL simul_edge5: got in1,in2=%b expected 00", {in1, in2});
    end
    tick(1);
    n_cmp++;
    if ({in1, in2, rise1, rise2} !== 4'b1111) begin
      n_err++;
      $display("FAIL simul_rise: got in1,in2,rise1,rise2=%b expected 1111", {in1, in2, rise1, rise2});
    end
    raw1 = 1'b0;
    raw2 = 1'b0;
    tick(6);
    n_cmp++;
    if ({in1, in2, fall1, fall2} !== 4'b0011) begin
      n_err++;
      $display("FAIL simul_fall: got in1,in2,fall1,fall2=%b expected 0011", {in1, in2, fall1, fall2});
    end
    tick(2);
  endtask

  task automatic test_fall_bounce();
    int f1;
    raw1 = 1'b1;
    tick(8);
    f1   = fall1_cnt;
    raw1 = 1'b0;
    tick(3);
    raw1 = 1'b1;
    tick(2);
    raw1 = 1'b0;
    tick(1);
    n_cmp++;
    if (in1 !== 1'b1) begin
      n_err++;
      $display("FAIL bounce_restart: got in1=%b expected 1", in1);
    end
    tick(4);
    n_cmp++;
    if (in1 !== 1'b1 || fall1_cnt != f1) begin
      n_err++;
      $display("FAIL bounce_edge10: got in1=%b falls=%0d expected 1 0", in1, fall1_cnt - f1);
    end
    tick(1);
    n_cmp++;
    if (in1 !== 1'b0 || fall1 !== 1'b1) begin
      n_err++;
      $display("FAIL bounce_fall: got in1=%b fall1=%b expected 0 1", in1, fall1);
    end
    tick(2);
  endtask

  task automatic test_reset_mid_wait();
    int p;
    raw2 = 1'b1;
    tick(8);
    raw1 = 1'b1;
    tick(4);
    n_cmp++;
    if ({in1, in2} !== 2'b01) begin
      n_err++;
      $display("FAIL midwait_pre: got in1,in2=%b expected 01", {in1, in2});
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({in1, in2, rise1, fall1, rise2, fall2} !== 6'b0) begin
      n_err++;
      $display("FAIL midwait_async: got %b expected 000000", {in1, in2, rise1, fall1, rise2, fall2});
    end
    tick(2);
    rst = 1'b0;
    p   = rise1_cnt + fall1_cnt + rise2_cnt + fall2_cnt;
    tick(5);
    n_cmp++;
    if ({in1, in2} !== 2'b00 || (rise1_cnt + fall1_cnt + rise2_cnt + fall2_cnt) != p) begin
      n_err++;
      $display("FAIL midwait_edge5: got in1,in2=%b pulses=%0d expected 00 0",
               {in1, in2}, rise1_cnt + fall1_cnt + rise2_cnt + fall2_cnt - p);
    end
    tick(1);
    n_cmp++;
    if ({in1, in2, rise1, rise2} !== 4'b1111) begin
      n_err++;
      $display("FAIL midwait_edge6: got in1,in2,rise1,rise2=%b expected 1111", {in1, in2, rise1, rise2});
    end
    tick(2);
  endtask

  task automatic test_nor_gate();
    logic [1:0] combos [4];
    logic       e1;
    logic       e2;
    logic       p1;
    logic       p2;
    int         er1;
    int         ef1;
    int         er2;
    int         ef2;
    int         r1;
    int         f1;
    int         r2;
    int         f2;
    combos[0] = 2'b00;
    combos[1] = 2'b01;
    combos[2] = 2'b11;
    combos[3] = 2'b10;
    p1 = 1'b1;
    p2 = 1'b1;
    er1 = 0; ef1 = 0; er2 = 0; ef2 = 0;
    r1 = rise1_cnt; f1 = fall1_cnt; r2 = rise2_cnt; f2 = fall2_cnt;
    for (int i = 0; i < 4; i++) begin
      e1   = combos[i][1];
      e2   = combos[i][0];
      raw1 = e1;
      raw2 = e2;
      tick(8);
      if (e1 && !p1) er1++;
      if (!e1 && p1) ef1++;
      if (e2 && !p2) er2++;
      if (!e2 && p2) ef2++;
      p1 = e1;
      p2 = e2;
      n_cmp++;
      if ({in1, in2, gate} !== {e1, e2, ~(e1 | e2)}) begin
        n_err++;
        $display("FAIL nor_combo%0d: got in1,in2,gate=%b expected %b",
                 i, {in1, in2, gate}, {e1, e2, ~(e1 | e2)});
      end
    end
    n_cmp++;
    if ((rise1_cnt - r1) != er1 || (fall1_cnt - f1) != ef1 ||
        (rise2_cnt - r2) != er2 || (fall2_cnt - f2) != ef2) begin
      n_err++;
      $display("FAIL nor_pulses: got r1=%0d f1=%0d r2=%0d f2=%0d expected %0d %0d %0d %0d",
               rise1_cnt - r1, fall1_cnt - f1, rise2_cnt - r2, fall2_cnt - f2,
               er1, ef1, er2, ef2);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rise1_cnt = 0;
    fall1_cnt = 0;
    rise2_cnt = 0;
    fall2_cnt = 0;
    rst       = 1'b1;
    raw1      = 1'b0;
    raw2      = 1'b0;
    test_reset();
    test_rise_latency();
    test_glitch();
    test_simultaneous();
    test_fall_bounce();
    test_reset_mid_wait();
    test_nor_gate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
